// File: rtl/ibex_wb_queue_if.sv
// Bundle between ID/EX and the multi-entry writeback queue: push side, LSU response side,
// forwarding lookups and the register-file write port.
interface ibex_wb_queue_if #(
   parameter int unsigned Depth = 2
);
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic            en_wb_i;
   logic [1:0]      instr_type_wb_i;
   logic [31:0]     pc_id_i;
   logic            instr_is_compressed_id_i;
   logic            instr_perf_count_id_i;
   logic [4:0]      rf_waddr_id_i;
   logic [31:0]     rf_wdata_id_i;
   logic            rf_we_id_i;
   logic            lsu_resp_valid_i;
   logic            lsu_resp_err_i;
   logic [31:0]     rf_wdata_lsu_i;
   logic            rf_we_lsu_i;
   logic [4:0]      rf_raddr_a_i;
   logic [4:0]      rf_raddr_b_i;
   logic            fwd_a_hit_o;
   logic [31:0]     fwd_a_data_o;
   logic            fwd_a_stall_o;
   logic            fwd_b_hit_o;
   logic [31:0]     fwd_b_data_o;
   logic            fwd_b_stall_o;
   logic            ready_wb_o;
   logic [4:0]      rf_waddr_wb_o;
   logic [31:0]     rf_wdata_wb_o;
   logic            rf_we_wb_o;
   logic            outstanding_load_wb_o;
   logic            outstanding_store_wb_o;
   logic [31:0]     pc_wb_o;
   logic            instr_done_wb_o;
   logic            perf_instr_ret_wb_o;
   logic            perf_instr_ret_compressed_wb_o;
   logic [CntW-1:0] occupancy_o;

   modport master (
      output en_wb_i, instr_type_wb_i, pc_id_i, instr_is_compressed_id_i,
             instr_perf_count_id_i, rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i,
             lsu_resp_valid_i, lsu_resp_err_i, rf_wdata_lsu_i, rf_we_lsu_i,
             rf_raddr_a_i, rf_raddr_b_i,
      input  fwd_a_hit_o, fwd_a_data_o, fwd_a_stall_o, fwd_b_hit_o, fwd_b_data_o,
             fwd_b_stall_o, ready_wb_o, rf_waddr_wb_o, rf_wdata_wb_o, rf_we_wb_o,
             outstanding_load_wb_o, outstanding_store_wb_o, pc_wb_o, instr_done_wb_o,
             perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o, occupancy_o
   );

   modport slave (
      input  en_wb_i, instr_type_wb_i, pc_id_i, instr_is_compressed_id_i,
             instr_perf_count_id_i, rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i,
             lsu_resp_valid_i, lsu_resp_err_i, rf_wdata_lsu_i, rf_we_lsu_i,
             rf_raddr_a_i, rf_raddr_b_i,
      output fwd_a_hit_o, fwd_a_data_o, fwd_a_stall_o, fwd_b_hit_o, fwd_b_data_o,
             fwd_b_stall_o, ready_wb_o, rf_waddr_wb_o, rf_wdata_wb_o, rf_we_wb_o,
             outstanding_load_wb_o, outstanding_store_wb_o, pc_wb_o, instr_done_wb_o,
             perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o, occupancy_o
   );
endinterface

// File: rtl/ibex_wb_queue.sv
// Multi-entry in-order writeback queue: retires from the head, lets ID/EX issue behind
// outstanding LSU ops and provides youngest-match operand forwarding / load-use stalls.
module ibex_wb_queue #(
   parameter int unsigned Depth    = 2,
   parameter bit          ResetAll = 1'b0
) (
   input logic            clk_i,
   input logic            rst_ni,
   ibex_wb_queue_if.slave io_wb
);
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   localparam logic [1:0] WbLoad  = 2'b00;
   localparam logic [1:0] WbStore = 2'b01;
   localparam logic [1:0] WbOther = 2'b10;

   typedef struct packed {
      logic [1:0]  ty;
      logic [31:0] pc;
      logic        comp;
      logic        perf;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        we;
   } entry_t;

   entry_t          r_entry [Depth];
   logic [Depth-1:0] r_valid;
   logic [PtrW-1:0] r_head, r_tail;
   logic [CntW-1:0] r_count;

   entry_t          w_head, w_push_entry;
   logic            w_head_valid, w_retire, w_ready, w_push, w_lsu_we, w_rf_we, w_perf;
   logic [PtrW-1:0] w_slot [Depth];
   logic [4:0]      w_raddr [2];
   logic [1:0]      w_fwd_hit, w_fwd_stall;
   logic [31:0]     w_fwd_data [2];

   function automatic logic [PtrW-1:0] inc_ptr(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_head       = r_entry[r_head];
   assign w_head_valid = r_valid[r_head];
   assign w_retire     = w_head_valid & ((w_head.ty == WbOther) | io_wb.lsu_resp_valid_i);
   // A full queue still accepts a push when the head leaves in the same cycle.
   assign w_ready      = (r_count < CntW'(Depth)) | w_retire;
   assign w_push       = io_wb.en_wb_i & w_ready;
   assign w_lsu_we     = io_wb.rf_we_lsu_i & w_retire & (w_head.ty == WbLoad);
   assign w_rf_we      = (w_retire & (w_head.ty == WbOther) & w_head.we) | w_lsu_we;
   assign w_perf       = w_retire & w_head.perf &
                         ~(io_wb.lsu_resp_valid_i & io_wb.lsu_resp_err_i);

   assign w_push_entry = '{ty:    io_wb.instr_type_wb_i,
                           pc:    io_wb.pc_id_i,
                           comp:  io_wb.instr_is_compressed_id_i,
                           perf:  io_wb.instr_perf_count_id_i,
                           waddr: io_wb.rf_waddr_id_i,
                           wdata: io_wb.rf_wdata_id_i,
                           we:    io_wb.rf_we_id_i};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_retire) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= inc_ptr(r_head);
         end
         if (w_push) begin
            r_valid[r_tail] <= 1'b1;
            r_tail          <= inc_ptr(r_tail);
         end
         if (w_push && !w_retire) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_retire) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   if (ResetAll) begin : g_payload_rst
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) r_entry[i] <= '0;
         end else if (w_push) begin
            r_entry[r_tail] <= w_push_entry;
         end
      end
   end else begin : g_payload_norst
      always_ff @(posedge clk_i) begin
         if (w_push) r_entry[r_tail] <= w_push_entry;
      end
   end

   // Slot index of the k-th oldest position, so later matches are younger.
   always_comb begin
      for (int k = 0; k < Depth; k++) begin
         w_slot[k] = (int'(r_head) + k >= Depth) ? PtrW'(int'(r_head) + k - Depth)
                                                 : PtrW'(int'(r_head) + k);
      end
   end

   assign w_raddr[0] = io_wb.rf_raddr_a_i;
   assign w_raddr[1] = io_wb.rf_raddr_b_i;

   always_comb begin
      for (int op = 0; op < 2; op++) begin
         w_fwd_hit[op]   = 1'b0;
         w_fwd_stall[op] = 1'b0;
         w_fwd_data[op]  = '0;
         for (int k = 0; k < Depth; k++) begin
            if (r_valid[w_slot[k]] && (w_raddr[op] != 5'd0) &&
                (r_entry[w_slot[k]].waddr == w_raddr[op]) &&
                (r_entry[w_slot[k]].we || (r_entry[w_slot[k]].ty == WbLoad))) begin
               w_fwd_stall[op] = (r_entry[w_slot[k]].ty == WbLoad);
               w_fwd_hit[op]   = (r_entry[w_slot[k]].ty != WbLoad);
               w_fwd_data[op]  = (r_entry[w_slot[k]].ty == WbLoad) ? '0
                                                                  : r_entry[w_slot[k]].wdata;
            end
         end
      end
   end

   always_comb begin
      io_wb.outstanding_load_wb_o  = 1'b0;
      io_wb.outstanding_store_wb_o = 1'b0;
      for (int i = 0; i < Depth; i++) begin
         if (r_valid[i] && (r_entry[i].ty == WbLoad))  io_wb.outstanding_load_wb_o  = 1'b1;
         if (r_valid[i] && (r_entry[i].ty == WbStore)) io_wb.outstanding_store_wb_o = 1'b1;
      end
      io_wb.ready_wb_o                     = w_ready;
      io_wb.rf_we_wb_o                     = w_rf_we;
      io_wb.rf_waddr_wb_o                  = w_head_valid ? w_head.waddr : 5'd0;
      io_wb.rf_wdata_wb_o                  = w_lsu_we ? io_wb.rf_wdata_lsu_i :
                                             (w_rf_we ? w_head.wdata : 32'd0);
      io_wb.pc_wb_o                        = w_head_valid ? w_head.pc : 32'd0;
      io_wb.instr_done_wb_o                = w_retire;
      io_wb.perf_instr_ret_wb_o            = w_perf;
      io_wb.perf_instr_ret_compressed_wb_o = w_perf & w_head.comp;
      io_wb.occupancy_o                    = r_count;
      io_wb.fwd_a_hit_o                    = w_fwd_hit[0];
      io_wb.fwd_a_stall_o                  = w_fwd_stall[0];
      io_wb.fwd_a_data_o                   = w_fwd_data[0];
      io_wb.fwd_b_hit_o                    = w_fwd_hit[1];
      io_wb.fwd_b_stall_o                  = w_fwd_stall[1];
      io_wb.fwd_b_data_o                   = w_fwd_data[1];
   end

   a_lsu_resp_head : assert property (@(posedge clk_i) disable iff (!rst_ni)
      io_wb.lsu_resp_valid_i |-> (w_head_valid && (w_head.ty != WbOther)));
   a_lsu_we_load : assert property (@(posedge clk_i) disable iff (!rst_ni)
      io_wb.rf_we_lsu_i |-> (io_wb.lsu_resp_valid_i && (w_head.ty == WbLoad)));
endmodule

// File: tb/tb_ibex_wb_queue.sv
// Directed + randomized bench for ibex_wb_queue against a queue-based reference model.
module tb_ibex_wb_queue;
   localparam int unsigned Depth = 3;
   localparam logic [1:0] TyLoad  = 2'b00;
   localparam logic [1:0] TyStore = 2'b01;
   localparam logic [1:0] TyOther = 2'b10;

   typedef struct {
      logic [1:0]  ty;
      logic [31:0] pc;
      logic        comp;
      logic        cnt;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        we;
   } ent_t;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   int   n_vec  = 0;
   int   n_err  = 0;
   ent_t mq[$];

   always #5 clk_i = ~clk_i;

   ibex_wb_queue_if #(.Depth(Depth)) u_if ();

   ibex_wb_queue #(.Depth(Depth), .ResetAll(1'b0)) u_dut (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .io_wb (u_if.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      u_if.en_wb_i = 0;                  u_if.instr_type_wb_i = TyOther;
      u_if.pc_id_i = 0;                  u_if.instr_is_compressed_id_i = 0;
      u_if.instr_perf_count_id_i = 0;    u_if.rf_waddr_id_i = 0;
      u_if.rf_wdata_id_i = 0;            u_if.rf_we_id_i = 0;
      u_if.lsu_resp_valid_i = 0;         u_if.lsu_resp_err_i = 0;
      u_if.rf_wdata_lsu_i = 0;           u_if.rf_we_lsu_i = 0;
      u_if.rf_raddr_a_i = 0;             u_if.rf_raddr_b_i = 0;
   endtask

   task automatic push_in(input logic [1:0] ty, input logic [4:0] wa, input logic [31:0] wd,
                          input logic we, input logic cnt);
      u_if.en_wb_i = 1;                  u_if.instr_type_wb_i = ty;
      u_if.pc_id_i = $urandom;           u_if.instr_is_compressed_id_i = 1'($urandom_range(0, 1));
      u_if.instr_perf_count_id_i = cnt;  u_if.rf_waddr_id_i = wa;
      u_if.rf_wdata_id_i = wd;           u_if.rf_we_id_i = we;
      u_if.lsu_resp_valid_i = 0;         u_if.lsu_resp_err_i = 0;
      u_if.rf_we_lsu_i = 0;              u_if.rf_wdata_lsu_i = 0;
   endtask

   // Youngest matching queued writer of ra decides forwarding.
   function automatic void fwd_model(input logic [4:0] ra, output logic hit, output logic stall,
                                     output logic [31:0] data);
      hit = 0; stall = 0; data = 0;
      for (int i = mq.size() - 1; i >= 0; i--) begin
         if (ra != 0 && mq[i].waddr == ra && (mq[i].we || mq[i].ty == TyLoad)) begin
            stall = (mq[i].ty == TyLoad);
            hit   = !stall;
            data  = stall ? 32'd0 : mq[i].wdata;
            break;
         end
      end
   endfunction

   task automatic sample(input string tag);
      ent_t h;
      logic hv, ret, rdy, we, perf, ld, st, ha, sa, hb, sb;
      logic [31:0] wd, da, db;
      @(negedge clk_i);
      hv = (mq.size() != 0);
      h  = '{ty: TyOther, default: '0};
      if (hv) h = mq[0];
      ret  = hv && (h.ty == TyOther || u_if.lsu_resp_valid_i);
      rdy  = (mq.size() < Depth) || ret;
      we   = (ret && h.ty == TyOther && h.we) || u_if.rf_we_lsu_i;
      wd   = u_if.rf_we_lsu_i ? u_if.rf_wdata_lsu_i : (we ? h.wdata : 32'd0);
      perf = ret && h.cnt && !(u_if.lsu_resp_valid_i && u_if.lsu_resp_err_i);
      ld = 0; st = 0;
      foreach (mq[i]) begin
         if (mq[i].ty == TyLoad)  ld = 1;
         if (mq[i].ty == TyStore) st = 1;
      end
      fwd_model(u_if.rf_raddr_a_i, ha, sa, da);
      fwd_model(u_if.rf_raddr_b_i, hb, sb, db);
      chk({tag, ".ready"},  32'(u_if.ready_wb_o), 32'(rdy));
      chk({tag, ".done"},   32'(u_if.instr_done_wb_o), 32'(ret));
      chk({tag, ".rf_we"},  32'(u_if.rf_we_wb_o), 32'(we));
      chk({tag, ".waddr"},  32'(u_if.rf_waddr_wb_o), 32'(hv ? h.waddr : 5'd0));
      chk({tag, ".wdata"},  u_if.rf_wdata_wb_o, wd);
      chk({tag, ".pc"},     u_if.pc_wb_o, hv ? h.pc : 32'd0);
      chk({tag, ".perf"},   32'(u_if.perf_instr_ret_wb_o), 32'(perf));
      chk({tag, ".perf_c"}, 32'(u_if.perf_instr_ret_compressed_wb_o), 32'(perf && h.comp));
      chk({tag, ".out_ld"}, 32'(u_if.outstanding_load_wb_o), 32'(ld));
      chk({tag, ".out_st"}, 32'(u_if.outstanding_store_wb_o), 32'(st));
      chk({tag, ".occ"},    32'(u_if.occupancy_o), 32'(mq.size()));
      chk({tag, ".hit_a"},  32'(u_if.fwd_a_hit_o), 32'(ha));
      chk({tag, ".stl_a"},  32'(u_if.fwd_a_stall_o), 32'(sa));
      chk({tag, ".dat_a"},  u_if.fwd_a_data_o, da);
      chk({tag, ".hit_b"},  32'(u_if.fwd_b_hit_o), 32'(hb));
      chk({tag, ".stl_b"},  32'(u_if.fwd_b_stall_o), 32'(sb));
      chk({tag, ".dat_b"},  u_if.fwd_b_data_o, db);
   endtask

   task automatic advance();
      logic ret, psh;
      ent_t e;
      ret = (mq.size() != 0) && (mq[0].ty == TyOther || u_if.lsu_resp_valid_i);
      psh = u_if.en_wb_i && ((mq.size() < Depth) || ret);
      e = '{ty: u_if.instr_type_wb_i, pc: u_if.pc_id_i, comp: u_if.instr_is_compressed_id_i,
            cnt: u_if.instr_perf_count_id_i, waddr: u_if.rf_waddr_id_i,
            wdata: u_if.rf_wdata_id_i, we: u_if.rf_we_id_i};
      @(posedge clk_i);
      if (!rst_ni) begin
         mq.delete();
      end else begin
         if (ret) void'(mq.pop_front());
         if (psh) mq.push_back(e);
      end
      #1;
   endtask

   task automatic step(input string tag);
      sample(tag);
      advance();
   endtask

   task automatic drain();
      for (int i = 0; i < 4 * Depth && mq.size() != 0; i++) begin
         idle();
         if (mq[0].ty != TyOther) begin
            u_if.lsu_resp_valid_i = 1;
            u_if.rf_we_lsu_i      = (mq[0].ty == TyLoad);
            u_if.rf_wdata_lsu_i   = $urandom;
         end
         step("drain");
      end
      idle();
      sample("drained");
      chk("drained.empty", 32'(u_if.occupancy_o), 32'd0);
      advance();
   endtask

   task automatic rand_inputs();
      push_in(2'($urandom_range(0, 2)), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      u_if.en_wb_i      = 1'($urandom_range(0, 1));
      u_if.rf_raddr_a_i = 5'($urandom_range(0, 7));
      u_if.rf_raddr_b_i = 5'($urandom_range(0, 7));
      if (mq.size() != 0 && mq[0].ty != TyOther && $urandom_range(0, 2) == 0) begin
         u_if.lsu_resp_valid_i = 1;
         u_if.lsu_resp_err_i   = ($urandom_range(0, 3) == 0);
         u_if.rf_we_lsu_i      = (mq[0].ty == TyLoad) && !u_if.lsu_resp_err_i &&
                                 1'($urandom_range(0, 1));
         u_if.rf_wdata_lsu_i   = $urandom;
      end
   endtask

   initial begin
      idle();
      sample("rst");
      chk("rst.ready_const", 32'(u_if.ready_wb_o), 32'd1);
      advance();
      rst_ni = 1;

      // Single OTHER write retires the cycle after it is pushed.
      push_in(TyOther, 5'd5, 32'h11, 1, 1);
      step("push_x5");
      idle();
      sample("ret_x5");
      chk("x5.we", 32'(u_if.rf_we_wb_o), 32'd1);
      chk("x5.waddr", 32'(u_if.rf_waddr_wb_o), 32'd5);
      chk("x5.wdata", u_if.rf_wdata_wb_o, 32'h11);
      chk("x5.done", 32'(u_if.instr_done_wb_o), 32'd1);
      advance();
      sample("x5_empty");
      chk("x5.occ0", 32'(u_if.occupancy_o), 32'd0);
      advance();

      // Load at head blocks the queue until its response; push into full queue on retire.
      push_in(TyLoad, 5'd3, 32'h0, 0, 1);    step("push_ld3");
      push_in(TyOther, 5'd4, 32'h44, 1, 1);  step("push_o4");
      push_in(TyOther, 5'd6, 32'h66, 1, 1);  step("push_o6");
      idle();
      sample("full");
      chk("full.occ", 32'(u_if.occupancy_o), Depth);
      chk("full.ready", 32'(u_if.ready_wb_o), 32'd0);
      chk("full.out_ld", 32'(u_if.outstanding_load_wb_o), 32'd1);
      advance();
      push_in(TyOther, 5'd9, 32'h99, 1, 1);
      u_if.lsu_resp_valid_i = 1;
      u_if.rf_we_lsu_i      = 1;
      u_if.rf_wdata_lsu_i   = 32'hDEAD;
      sample("ld_resp");
      chk("ld_resp.ready", 32'(u_if.ready_wb_o), 32'd1);
      chk("ld_resp.waddr", 32'(u_if.rf_waddr_wb_o), 32'd3);
      chk("ld_resp.wdata", u_if.rf_wdata_wb_o, 32'hDEAD);
      advance();
      idle();
      sample("o4_ret");
      chk("o4.occ_kept", 32'(u_if.occupancy_o), Depth);
      chk("o4.waddr", 32'(u_if.rf_waddr_wb_o), 32'd4);
      advance();
      drain();

      // Forwarding: youngest writer wins, younger load forces a stall, x0 never matches.
      push_in(TyStore, 5'd0, 32'h0, 0, 1);   step("push_st");
      push_in(TyOther, 5'd7, 32'h1, 1, 1);   step("push_o7a");
      push_in(TyOther, 5'd7, 32'h2, 1, 1);   step("push_o7b");
      idle();
      u_if.rf_raddr_a_i = 5'd7;
      u_if.rf_raddr_b_i = 5'd0;
      sample("fwd");
      chk("fwd.hit_a", 32'(u_if.fwd_a_hit_o), 32'd1);
      chk("fwd.dat_a", u_if.fwd_a_data_o, 32'h2);
      chk("fwd.hit_b", 32'(u_if.fwd_b_hit_o), 32'd0);
      advance();
      push_in(TyLoad, 5'd7, 32'h0, 0, 1);
      u_if.lsu_resp_valid_i = 1;
      step("st_resp");
      idle();
      u_if.rf_raddr_a_i = 5'd7;
      sample("fwd_ld");
      chk("fwd_ld.stall_a", 32'(u_if.fwd_a_stall_o), 32'd1);
      chk("fwd_ld.hit_a", 32'(u_if.fwd_a_hit_o), 32'd0);
      advance();
      drain();

      // Errored store response retires without counting or writing.
      push_in(TyStore, 5'd2, 32'h5, 0, 1);
      step("push_st_err");
      idle();
      u_if.lsu_resp_valid_i = 1;
      u_if.lsu_resp_err_i   = 1;
      sample("st_err");
      chk("st_err.done", 32'(u_if.instr_done_wb_o), 32'd1);
      chk("st_err.perf", 32'(u_if.perf_instr_ret_wb_o), 32'd0);
      chk("st_err.rf_we", 32'(u_if.rf_we_wb_o), 32'd0);
      advance();

      for (int i = 0; i < 600; i++) begin
         rand_inputs();
         step("rand");
      end
      drain();

      // Asynchronous reset with entries in flight.
      push_in(TyLoad, 5'd1, 32'h0, 0, 1);    step("push_ld1");
      push_in(TyLoad, 5'd2, 32'h0, 0, 1);    step("push_ld2");
      idle();
      rst_ni = 0;
      mq.delete();
      #1;
      chk("arst.occ", 32'(u_if.occupancy_o), 32'd0);
      chk("arst.ready", 32'(u_if.ready_wb_o), 32'd1);
      chk("arst.out_ld", 32'(u_if.outstanding_load_wb_o), 32'd0);
      chk("arst.pc", u_if.pc_wb_o, 32'd0);
      step("in_rst");
      rst_ni = 1;
      step("post_rst0");
      sample("post_rst1");
      chk("post_rst.done", 32'(u_if.instr_done_wb_o), 32'd0);
      advance();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
